// File: rtl/epcs_cmd_seq.sv
// EPCS serial-flash command sequencer: expands one CPU request into WREN / opcode / RDSR-poll
// frames and drives the start / clk_end / wr_data inputs of the downstream spi master.
module epcs_cmd_seq #(
    parameter int unsigned GAP_CYC  = 4,
    parameter int unsigned POLL_MAX = 1048575,
    parameter int unsigned HI_WAIT  = 3
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        timeout,
    output logic        busy,
    output logic        spi_start,
    output logic [5:0]  spi_clk_end,
    output logic [63:0] spi_wr_data,
    input  logic        spi_busy,
    input  logic [7:0]  spi_rd_byte
);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int HI_W  = $clog2(HI_WAIT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [HI_W-1:0]  HI_LAST  = HI_W'(HI_WAIT - 1);
    localparam logic [19:0]      POLL_LIM = 20'(POLL_MAX);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_GAP, S_FIN} state_t;
    typedef enum logic [2:0] {F_WREN, F_READ, F_PROG, F_ERASE, F_RDSR} frame_t;

    function automatic frame_t step_frame(input logic [1:0] op, input logic [1:0] step);
        case (op)
            2'd0:    return F_READ;
            2'd1:    return (step == 2'd0) ? F_WREN : (step == 2'd1) ? F_PROG : F_RDSR;
            2'd2:    return (step == 2'd0) ? F_WREN : (step == 2'd1) ? F_ERASE : F_RDSR;
            default: return F_RDSR;
        endcase
    endfunction

    function automatic logic [5:0] frame_clk_end(input frame_t f);
        case (f)
            F_WREN:  return 6'd8;
            F_READ:  return 6'd40;
            F_PROG:  return 6'd40;
            F_ERASE: return 6'd32;
            default: return 6'd16;
        endcase
    endfunction

    function automatic logic [63:0] frame_data(input frame_t f, input logic [23:0] addr,
                                               input logic [7:0] wdata);
        case (f)
            F_WREN:  return {8'h06, 56'd0};
            F_READ:  return {8'h03, addr, 32'd0};
            F_PROG:  return {8'h02, addr, wdata, 24'd0};
            F_ERASE: return {8'hD8, addr, 32'd0};
            default: return {8'h05, 56'd0};
        endcase
    endfunction

    state_t           r_state;
    frame_t           r_frame;
    logic [1:0]       r_op;
    logic [1:0]       r_step;
    logic [23:0]      r_addr;
    logic [7:0]       r_wdata;
    logic [19:0]      r_poll_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [HI_W-1:0]  r_hi_cnt;
    logic             r_cmd_ready;
    logic             r_done;
    logic             r_timeout;
    logic [7:0]       r_rd_data;
    logic             r_spi_start;
    logic [5:0]       r_clk_end;
    logic [63:0]      r_wr_data;

    logic [1:0]  w_last_step;
    logic        w_poll_op;
    logic        w_more;
    frame_t      w_ld_frame;
    logic [5:0]  w_ld_clk_end;
    logic [63:0] w_ld_data;

    // Next frame to load: first step of the incoming command in IDLE, else the following step
    // (or another RDSR once the step list is exhausted).
    always_comb begin
        w_last_step  = (r_op == 2'd1 || r_op == 2'd2) ? 2'd2 : 2'd0;
        w_poll_op    = (r_op == 2'd1 || r_op == 2'd2);
        w_more       = (r_step != w_last_step) ||
                       (w_poll_op && r_rd_data[0] && (r_poll_cnt < POLL_LIM));
        if (r_state == S_IDLE) begin
            w_ld_frame = step_frame(cmd_op, 2'd0);
            w_ld_data  = frame_data(w_ld_frame, cmd_addr, cmd_wdata);
        end else begin
            w_ld_frame = (r_step != w_last_step) ? step_frame(r_op, r_step + 2'd1) : F_RDSR;
            w_ld_data  = frame_data(w_ld_frame, r_addr, r_wdata);
        end
        w_ld_clk_end = frame_clk_end(w_ld_frame);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= S_IDLE;
            r_frame     <= F_WREN;
            r_op        <= 2'd0;
            r_step      <= 2'd0;
            r_addr      <= 24'd0;
            r_wdata     <= 8'd0;
            r_poll_cnt  <= 20'd0;
            r_gap_cnt   <= '0;
            r_hi_cnt    <= '0;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_rd_data   <= 8'd0;
            r_spi_start <= 1'b0;
            r_clk_end   <= 6'd0;
            r_wr_data   <= 64'd0;
        end else begin
            // NOTE: pulses default low every cycle; only the state transitions below raise them.
            r_spi_start <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: if (cmd_valid && r_cmd_ready) begin
                    r_op        <= cmd_op;
                    r_addr      <= cmd_addr;
                    r_wdata     <= cmd_wdata;
                    r_step      <= 2'd0;
                    r_poll_cnt  <= 20'd0;
                    r_timeout   <= 1'b0;
                    r_cmd_ready <= 1'b0;
                    r_frame     <= w_ld_frame;
                    r_clk_end   <= w_ld_clk_end;
                    r_wr_data   <= w_ld_data;
                    r_spi_start <= 1'b1;
                    r_state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_hi_cnt <= '0;
                    r_state  <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (spi_busy) begin
                        r_state <= S_WAIT_LO;
                    end else if (r_hi_cnt == HI_LAST) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_FIN;
                    end else begin
                        r_hi_cnt <= r_hi_cnt + 1'b1;
                    end
                end
                S_WAIT_LO: if (!spi_busy) begin
                    if (r_frame == F_READ || r_frame == F_RDSR) r_rd_data <= spi_rd_byte;
                    r_gap_cnt <= '0;
                    r_state   <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap_cnt != GAP_LAST) begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end else if (w_more) begin
                        if (r_step != w_last_step) r_step <= r_step + 2'd1;
                        else                       r_poll_cnt <= r_poll_cnt + 20'd1;
                        r_frame     <= w_ld_frame;
                        r_clk_end   <= w_ld_clk_end;
                        r_wr_data   <= w_ld_data;
                        r_spi_start <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else begin
                        // Still busy after the last permitted poll: give up with timeout.
                        if (w_poll_op && r_rd_data[0]) r_timeout <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign busy        = ~r_cmd_ready;
    assign done        = r_done;
    assign rd_data     = r_rd_data;
    assign timeout     = r_timeout;
    assign spi_start   = r_spi_start;
    assign spi_clk_end = r_clk_end;
    assign spi_wr_data = r_wr_data;
endmodule

// File: tb/tb_epcs_cmd_seq.sv
// Scoreboard bench for epcs_cmd_seq: a reference model queues expected frames and results,
// a behavioural spi responder answers frames, and a monitor compares what the DUT presents.
module tb_epcs_cmd_seq;
    localparam int GAP_CYC  = 4;
    localparam int POLL_MAX = 5;
    localparam int HI_WAIT  = 3;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [23:0] cmd_addr = 24'd0;
    logic [7:0]  cmd_wdata = 8'd0;
    logic        done;
    logic [7:0]  rd_data;
    logic        timeout;
    logic        busy;
    logic        spi_start;
    logic [5:0]  spi_clk_end;
    logic [63:0] spi_wr_data;
    logic        spi_busy = 1'b0;
    logic [7:0]  spi_rd_byte = 8'd0;

    always #5 clk = ~clk;

    epcs_cmd_seq #(.GAP_CYC(GAP_CYC), .POLL_MAX(POLL_MAX), .HI_WAIT(HI_WAIT)) dut (
        .clk(clk), .rstb(rstb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .done(done),
        .rd_data(rd_data), .timeout(timeout), .busy(busy), .spi_start(spi_start),
        .spi_clk_end(spi_clk_end), .spi_wr_data(spi_wr_data), .spi_busy(spi_busy),
        .spi_rd_byte(spi_rd_byte)
    );

    typedef struct {
        logic [5:0]  clk_end;
        logic [63:0] data;
    } frame_s;
    typedef struct {
        logic [7:0] rd;
        logic       to;
    } res_s;

    frame_s     exp_frames[$];
    res_s       exp_res[$];
    logic [7:0] resp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         no_busy = 1'b0;
    int         frames_started = 0;
    logic [7:0] exp_rd_last = 8'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic frame_s mk(input logic [7:0] opc, input int nclk, input logic [55:0] payload);
        frame_s f;
        f.clk_end = 6'(nclk);
        f.data    = {opc, payload};
        return f;
    endfunction

    // Reference model: frame list and final result of one command, from the protocol rules.
    // n_busy = number of leading status reads that still report WIP; exact forces 01h/00h.
    task automatic plan(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] wd,
                        input logic [7:0] val, input int n_busy, input bit exact);
        res_s       r;
        logic [7:0] s;
        r.rd = exp_rd_last;
        r.to = 1'b0;
        if (op == 2'd0 || op == 2'd3) begin
            exp_frames.push_back(op == 2'd0 ? mk(8'h03, 40, {addr, 32'd0}) : mk(8'h05, 16, 56'd0));
            resp_q.push_back(val);
            r.rd = val;
        end else begin
            exp_frames.push_back(mk(8'h06, 8, 56'd0));
            resp_q.push_back(8'($urandom));
            exp_frames.push_back(op == 2'd1 ? mk(8'h02, 40, {addr, wd, 24'd0})
                                            : mk(8'hD8, 32, {addr, 32'd0}));
            resp_q.push_back(8'($urandom));
            for (int i = 0; i <= POLL_MAX; i++) begin
                s    = exact ? 8'h00 : 8'($urandom);
                s[0] = (i < n_busy);
                exp_frames.push_back(mk(8'h05, 16, 56'd0));
                resp_q.push_back(s);
                r.rd = s;
                if (!s[0]) break;
                if (i == POLL_MAX) r.to = 1'b1;
            end
        end
        exp_res.push_back(r);
        exp_rd_last = r.rd;
    endtask

    task automatic send(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] wd);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(cmd_ready), 64'd1);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("timeout_cleared_on_accept", 64'(timeout), 64'd0);
        check("ready_low_after_accept", 64'(cmd_ready), 64'd0);
        // A strobe while busy must be ignored.
        cmd_addr  = 24'($urandom);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_res.size() != 0 || !cmd_ready) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(exp_res.size()), 64'd0);
        check("frames_consumed", 64'(exp_frames.size()), 64'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_spi_start", 64'(spi_start), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_clk_end", 64'(spi_clk_end), 64'd0);
        check("rst_wr_data", spi_wr_data, 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
    endtask

    // Behavioural spi master: busy rises 0-1 cycles after start, lasts a few cycles, and the
    // read byte is only valid in the cycle busy is first low.
    initial begin
        int         st = 0;
        int         cnt = 0;
        logic [7:0] cur = 8'd0;
        forever begin
            @(negedge clk);
            spi_rd_byte = 8'($urandom);
            if (!rstb) begin
                spi_busy = 1'b0;
                st       = 0;
            end else begin
                case (st)
                    0: if (spi_start && !no_busy) begin
                        frames_started++;
                        cur = (resp_q.size() != 0) ? resp_q.pop_front() : 8'($urandom);
                        cnt = $urandom_range(2, 8);
                        if ($urandom_range(0, 1) == 0) begin
                            spi_busy = 1'b1;
                            st       = 2;
                        end else begin
                            st = 1;
                        end
                    end
                    1: begin
                        spi_busy = 1'b1;
                        st       = 2;
                    end
                    default: begin
                        if (cnt == 0) begin
                            spi_busy    = 1'b0;
                            spi_rd_byte = cur;
                            st          = 0;
                        end else begin
                            cnt--;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: compares frames on every start pulse and results on every done pulse.
    initial begin
        bit     prev_start = 1'b0;
        int     low_run = 1000;
        frame_s cur_f;
        res_s   r;
        cur_f.clk_end = 6'd0;
        cur_f.data    = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstb) begin
                prev_start = 1'b0;
                low_run    = 1000;
            end else begin
                check("busy_is_not_ready", 64'(busy), 64'(cmd_ready == 1'b0));
                if (spi_start) begin
                    check("start_single_cycle", 64'(prev_start), 64'd0);
                    check("start_gap", 64'(low_run >= GAP_CYC), 64'd1);
                    if (exp_frames.size() == 0) begin
                        check("frame_expected", 64'(exp_frames.size() != 0), 64'd1);
                    end else begin
                        cur_f = exp_frames.pop_front();
                        check("frame_clk_end", 64'(spi_clk_end), 64'(cur_f.clk_end));
                        check("frame_wr_data", spi_wr_data, cur_f.data);
                    end
                    low_run = 0;
                end else begin
                    low_run++;
                end
                prev_start = spi_start;
                if (spi_busy) check("frame_held", spi_wr_data, cur_f.data);
                if (done) begin
                    if (exp_res.size() == 0) begin
                        check("done_expected", 64'(exp_res.size() != 0), 64'd1);
                    end else begin
                        r = exp_res.pop_front();
                        check("result_rd_data", 64'(rd_data), 64'(r.rd));
                        check("result_timeout", 64'(timeout), 64'(r.to));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         n_acc;
        int         base;
        logic [1:0] op;
        int         nb;

        #1 rstb = 1'b0;
        #12;
        check_reset_vals();
        @(negedge clk);
        rstb = 1'b1;

        // Single read byte.
        plan(2'd0, 24'h012345, 8'h00, 8'hA5, 0, 1'b1);
        send(2'd0, 24'h012345, 8'h00);
        wait_done();

        // Program byte with two busy polls.
        plan(2'd1, 24'h000100, 8'h3C, 8'h00, 2, 1'b1);
        send(2'd1, 24'h000100, 8'h3C);
        wait_done();

        // Sector erase with status stuck busy: poll limit reached.
        plan(2'd2, 24'h030000, 8'h00, 8'h00, 100, 1'b1);
        send(2'd2, 24'h030000, 8'h00);
        wait_done();
        check("timeout_after_poll_limit", 64'(timeout), 64'd1);

        // spi never raises busy.
        no_busy = 1'b1;
        exp_frames.push_back(mk(8'h03, 40, {24'h00ABCD, 32'd0}));
        exp_res.push_back('{exp_rd_last, 1'b1});
        send(2'd0, 24'h00ABCD, 8'h00);
        wait_done();
        check("timeout_sticky", 64'(timeout), 64'd1);
        no_busy = 1'b0;

        // Reset in the middle of the PROG frame, then a status read.
        base = frames_started;
        plan(2'd1, 24'h123456, 8'h77, 8'h00, 1, 1'b0);
        send(2'd1, 24'h123456, 8'h77);
        n = 0;
        while (!(frames_started == base + 2 && spi_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_prog_frame", 64'(frames_started == base + 2), 64'd1);
        #2 rstb = 1'b0;
        #1;
        check_reset_vals();
        exp_frames.delete();
        exp_res.delete();
        resp_q.delete();
        exp_rd_last = 8'd0;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        plan(2'd3, 24'h000000, 8'h00, 8'h5A, 0, 1'b1);
        send(2'd3, 24'h000000, 8'h00);
        wait_done();

        // cmd_valid held across two back-to-back reads.
        plan(2'd0, 24'h0F0F0F, 8'h00, 8'($urandom), 0, 1'b0);
        plan(2'd0, 24'h0F0F0F, 8'h00, 8'($urandom), 0, 1'b0);
        @(negedge clk);
        cmd_op    = 2'd0;
        cmd_addr  = 24'h0F0F0F;
        cmd_valid = 1'b1;
        n_acc     = 0;
        n         = 0;
        while (n < 20000) begin
            if (cmd_ready) n_acc++;
            if (n_acc == 2) break;
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_valid_accepts", 64'(n_acc), 64'd2);
        wait_done();
        repeat (20) @(negedge clk);
        check("no_extra_accept", 64'(cmd_ready), 64'd1);

        // Randomized commands.
        for (int k = 0; k < 24; k++) begin
            op = 2'($urandom_range(0, 3));
            nb = ($urandom_range(0, 4) == 0) ? POLL_MAX + 3 : int'($urandom_range(0, 3));
            cmd_addr  = 24'($urandom);
            cmd_wdata = 8'($urandom);
            plan(op, cmd_addr, cmd_wdata, 8'($urandom), nb, 1'b0);
            send(op, cmd_addr, cmd_wdata);
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/epcs_cmd_seq.md
Name: epcs_cmd_seq

Overview:
Command sequencer that sits directly upstream of the `spi` master and drives its start / clk_end / wr_data inputs.
- Turns one CPU-level flash request (read byte, program byte, sector erase, read status) into the full EPCS/serial-flash frame sequence.
- Sequence is WREN, then the opcode frame, then RDSR polling until WIP clears.
- Frees the `epcsrw` I/O layer from software-driven write-enable and busy polling.

Parameters:
- GAP_CYC, 4: clk cycles of idle between consecutive SPI frames (nCS high time); must be ≥2.
- POLL_MAX, 1048575: maximum RDSR frames issued before timeout; 20-bit.
- HI_WAIT, 3: cycles allowed for spi_busy to rise after spi_start before the frame is declared failed.

Ports:
- clk  in  1  system clock (50 MHz)
- rstb  in  1  asynchronous active-low reset
- cmd_valid  in  1  request strobe
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready
- cmd_op  in  2  0=read byte, 1=program byte, 2=sector erase, 3=read status
- cmd_addr  in  24  flash byte address
- cmd_wdata  in  8  program data
- done  out  1  one-cycle pulse at command completion (success or failure)
- rd_data  out  8  read byte (op0) or status byte (op3, and final RDSR of op1/op2)
- timeout  out  1  sticky error flag, cleared on next accepted command
- busy  out  1  ~cmd_ready
- spi_start  out  1  to spi.start; edge-detected downstream
- spi_clk_end  out  6  to spi.clk_end, number of SCLKs in the frame
- spi_wr_data  out  64  to spi.wr_data, MSB first
- spi_busy  in  1  from spi.busy
- spi_rd_byte  in  8  from spi.rd_1byte; valid in the cycle spi_busy is first seen low after a frame

Behaviour:
Reset (async, rstb=0):
- State IDLE.
- spi_start, done, timeout, rd_data, spi_clk_end, spi_wr_data, poll counter all 0.
- cmd_ready=1.

Command capture:
- On acceptance, cmd_op, cmd_addr and cmd_wdata are registered; timeout is cleared.
- cmd_valid while busy is ignored (no queueing).

Frame encodings:
- WREN: clk_end 8, wr_data {06h, 56'd0}
- READ: clk_end 40, wr_data {03h, addr, 32'd0}
- PROG: clk_end 40, wr_data {02h, addr, wdata, 24'd0}
- ERASE: clk_end 32, wr_data {D8h, addr, 32'd0}
- RDSR: clk_end 16, wr_data {05h, 56'd0}

Step order per op:
- op0: READ
- op1: WREN, PROG, RDSR-poll
- op2: WREN, ERASE, RDSR-poll
- op3: RDSR once, no poll

Frame FSM (IDLE, ISSUE, WAIT_HI, WAIT_LO, GAP, FIN):
- IDLE → ISSUE in the cycle after acceptance. spi_clk_end and spi_wr_data are loaded on entry to ISSUE and held stable until WAIT_LO exits.
- ISSUE: spi_start=1 for exactly this one cycle → WAIT_HI.
- WAIT_HI: on spi_busy=1 → WAIT_LO. If HI_WAIT cycles elapse without it → set timeout → FIN.
- WAIT_LO: stay while spi_busy=1. On spi_busy=0, capture spi_rd_byte into rd_data for READ/RDSR frames only → GAP.
- GAP: count GAP_CYC cycles with spi_start=0, then select the next step:
  - More steps remain → ISSUE with the next frame.
  - Poll step, rd_data[0]=1 and poll count < POLL_MAX → ISSUE another RDSR, count+1.
  - Poll step, rd_data[0]=1 and count = POLL_MAX → set timeout → FIN.
  - Otherwise → FIN.
- FIN: done=1 for one cycle → IDLE.

Latency and ordering:
- Latency op0 = 1 (ISSUE) + 1 (rise) + frame length + GAP_CYC + 1 (FIN) cycles, with frame length 40×11 at the spi default bit period.
- spi_start is never high in two consecutive cycles and is always preceded by ≥GAP_CYC low cycles. This guarantees a fresh rising edge for every frame.
- Poll counter is 20-bit and saturating. It counts RDSR frames only, excluding the first.
- Reset mid-operation aborts immediately: spi_start=0 and no done pulse. Downstream spi is reset by the same rstb.
- done and a new cmd_valid may coincide: the command is not accepted until the next cycle, when IDLE/cmd_ready=1.

Test Plan:
1. op0, addr 012345h; SPI model returns A5h → one frame, clk_end 40, wr_data 0301234500000000h; rd_data A5h; one done pulse; timeout 0.
2. op1, addr 000100h, wdata 3Ch; model status 01h, 01h, 00h → frames in order WREN(8), PROG(40, 0200010 03C000000h), RDSR×3; done after third RDSR; rd_data 00h.
3. op2, addr 030000h; status stuck 01h; POLL_MAX=5 → WREN, ERASE(32, D803000000000000h), then 6 RDSR frames; timeout=1 with done; next accepted command clears timeout.
4. Model never raises spi_busy → after HI_WAIT cycles: timeout=1, done pulse, return to IDLE, spi_start pulsed exactly once.
5. Assert rstb=0 during PROG frame of op1 → all outputs at reset values asynchronously, no done; after release, op3 completes normally with status byte returned.
6. Hold cmd_valid high continuously across two op0 commands → exactly two acceptances, separated by the full sequence; spi_start rising edges spaced ≥GAP_CYC apart.
